// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding, PC step and
// branch immediate scaling.
package pc_sequencer_pkg;

    localparam int DEFAULT_XLEN = 64;
    localparam int INST_W       = 32;

    // Sequential fetch step and branch immediate scaling (halfword units).
    localparam int PC_INC   = 4;
    localparam int BR_SHIFT = 1;

    // Fetch FSM states, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_BOOT = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_HOLD = 3'd3;
    localparam state_t ST_TRAP = 3'd4;  // only reachable with PC_SEQ_MISALIGN_TRAP_EN

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction memory request/response channel between the sequencer
// (master) and the instruction memory (slave).
interface pc_sequencer_if #(
    parameter int XLEN = pc_sequencer_pkg::DEFAULT_XLEN
);
    logic                                 req_valid;
    logic                                 req_ready;
    logic [XLEN-1:0]                      req_addr;
    logic                                 rsp_valid;
    logic [pc_sequencer_pkg::INST_W-1:0]  rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pc_sequencer_pc_next_calc.sv
// Combinational next-PC helper: sequential increment, branch target and
// the taken decision. Both sums wrap modulo 2^XLEN.
module pc_next_calc
    import pc_sequencer_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_br_valid,
    input  logic            i_br_branch,
    input  logic            i_br_zero,
    input  logic [XLEN-1:0] i_br_pc,
    input  logic [XLEN-1:0] i_br_imm,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_target,
    output logic            o_taken
);

    assign o_pc_plus4 = i_pc + XLEN'(PC_INC);
    assign o_target   = i_br_pc + (i_br_imm << BR_SHIFT);
    assign o_taken    = i_br_valid & i_br_branch & i_br_zero;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: issues one instruction fetch at a time, presents the
// returned instruction to decode, holds it under stall and redirects on
// taken branches.
// Optional feature macro: PC_SEQ_MISALIGN_TRAP_EN (trap on target[1]=1).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    imem,
    input  logic              i_stall,
    output logic              o_inst_valid,
    output logic [XLEN-1:0]   o_inst_pc,
    output logic [INST_W-1:0] o_inst_data,
    input  logic              i_br_valid,
    input  logic              i_br_branch,
    input  logic              i_br_zero,
    input  logic [XLEN-1:0]   i_br_pc,
    input  logic [XLEN-1:0]   i_br_imm,
    output logic              o_redirect
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    ,
    output logic              o_misalign_trap
`endif
);

    state_t              r_state;
    logic [XLEN-1:0]     r_pc;
    logic                r_discard;
    logic                r_inst_valid;
    logic [XLEN-1:0]     r_inst_pc;
    logic [INST_W-1:0]   r_inst_data;
    logic                r_redirect;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic                r_trap;
`endif

    logic [XLEN-1:0]     w_pc_plus4;
    logic [XLEN-1:0]     w_target;
    logic                w_taken;

    pc_next_calc #(.XLEN(XLEN)) u_next (
        .i_pc        (r_pc),
        .i_br_valid  (i_br_valid),
        .i_br_branch (i_br_branch),
        .i_br_zero   (i_br_zero),
        .i_br_pc     (i_br_pc),
        .i_br_imm    (i_br_imm),
        .o_pc_plus4  (w_pc_plus4),
        .o_target    (w_target),
        .o_taken     (w_taken)
    );

    // Fetch FSM, PC and presentation registers; a taken branch overrides the normal step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_discard    <= 1'b0;
            r_inst_valid <= 1'b0;
            // NOTE: the holding register is reset too, so decode never sees X on inst_pc/inst_data.
            r_inst_pc    <= '0;
            r_inst_data  <= '0;
            r_redirect   <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            r_trap       <= 1'b0;
`endif
        end else begin
            // Pulses default low; the presented instruction lasts one cycle unless held.
            r_redirect   <= 1'b0;
            r_inst_valid <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            r_trap       <= 1'b0;
`endif
            case (r_state)
                ST_BOOT: r_state <= ST_REQ;
                ST_REQ: begin
                    if (imem.req_ready) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Responses are only meaningful here; elsewhere they are stale.
                    if (imem.rsp_valid) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= ST_REQ;
                        end else begin
                            r_inst_valid <= 1'b1;
                            r_inst_pc    <= r_pc;
                            r_inst_data  <= imem.rsp_data;
                            if (i_stall) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_pc    <= w_pc_plus4;
                                r_state <= ST_REQ;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_stall) begin
                        r_inst_valid <= 1'b1;
                    end else begin
                        r_pc    <= w_pc_plus4;
                        r_state <= ST_REQ;
                    end
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_BOOT;
            endcase

            // NOTE: these later non-blocking assignments win over the ones above, so the redirect takes priority.
            if (w_taken && (r_state != ST_TRAP)) begin
                r_inst_valid <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
                if (w_target[1]) begin
                    r_trap    <= 1'b1;
                    r_discard <= 1'b0;
                    r_state   <= ST_TRAP;
                end else
`endif
                begin
                    r_redirect <= 1'b1;
                    r_pc       <= w_target;
                    case (r_state)
                        ST_REQ: begin
                            // A request accepted this same cycle still returns data to throw away.
                            r_discard <= imem.req_ready;
                            r_state   <= imem.req_ready ? ST_WAIT : ST_REQ;
                        end
                        ST_WAIT: begin
                            r_discard <= ~imem.rsp_valid;
                            r_state   <= imem.rsp_valid ? ST_REQ : ST_WAIT;
                        end
                        default: begin
                            r_discard <= 1'b0;
                            r_state   <= ST_REQ;
                        end
                    endcase
                end
            end
        end
    end

    assign imem.req_valid = (r_state == ST_REQ);
    assign imem.req_addr  = r_pc;
    assign o_inst_valid   = r_inst_valid;
    assign o_inst_pc      = r_inst_pc;
    assign o_inst_data    = r_inst_data;
    assign o_redirect     = r_redirect;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign o_misalign_trap = r_trap;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a small instruction
// memory model whose response latency is adjustable.
// Honours PC_SEQ_MISALIGN_TRAP_EN for the misaligned-target case.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic [31:0] inst_data;
    logic        br_valid;
    logic        br_branch;
    logic        br_zero;
    logic [63:0] br_pc;
    logic [63:0] br_imm;
    logic        redirect;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state.
    logic        pend;
    int          pend_cnt;
    logic [63:0] pend_addr;
    int          rsp_delay;

    pc_sequencer_if #(.XLEN(64)) imem ();

    pc_sequencer #(.XLEN(64), .RESET_VECTOR(64'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem),
        .i_stall      (stall),
        .o_inst_valid (inst_valid),
        .o_inst_pc    (inst_pc),
        .o_inst_data  (inst_data),
        .i_br_valid   (br_valid),
        .i_br_branch  (br_branch),
        .i_br_zero    (br_zero),
        .i_br_pc      (br_pc),
        .i_br_imm     (br_imm),
        .o_redirect   (redirect)
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        ,
        .o_misalign_trap (misalign_trap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mk_data(input logic [63:0] addr);
        return addr[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the memory model sees handshakes just before the edge and
    // updates its response 1 time unit after it.
    task automatic tick();
        logic        acc;
        logic [63:0] a;
        acc = imem.req_valid && imem.req_ready;
        a   = imem.req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = rsp_delay;
            pend_addr = a;
        end
        if (pend && pend_cnt == 0) begin
            imem.rsp_valid = 1'b1;
            imem.rsp_data  = mk_data(pend_addr);
            pend           = 1'b0;
        end else begin
            imem.rsp_valid = 1'b0;
            imem.rsp_data  = '0;
            if (pend) pend_cnt--;
        end
    endtask

    task automatic set_branch(input logic [63:0] pc, input logic [63:0] imm);
        br_valid  = 1'b1;
        br_branch = 1'b1;
        br_zero   = 1'b1;
        br_pc     = pc;
        br_imm    = imm;
    endtask

    task automatic clear_branch();
        br_valid  = 1'b0;
        br_branch = 1'b0;
        br_zero   = 1'b0;
    endtask

    // From a visible request at p: accept, respond, present.
    task automatic fetch_one(input logic [63:0] p);
        check("req_valid", 64'(imem.req_valid), 64'd1);
        check("req_addr", imem.req_addr, p);
        tick();
        check("inst_valid_wait", 64'(inst_valid), 64'd0);
        tick();
        check("inst_valid", 64'(inst_valid), 64'd1);
        check("inst_pc", inst_pc, p);
        check("inst_data", 64'(inst_data), 64'(mk_data(p)));
        check("redirect_idle", 64'(redirect), 64'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        br_valid = 1'b0; br_branch = 1'b0; br_zero = 1'b0; br_pc = '0; br_imm = '0;
        imem.req_ready = 1'b1; imem.rsp_valid = 1'b0; imem.rsp_data = '0;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0; rsp_delay = 0;

        // Reset state.
        tick(); tick();
        check("rst_req_valid", 64'(imem.req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_inst_data", 64'(inst_data), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        check("rst_trap", 64'(misalign_trap), 64'd0);
`endif
        reset = 1'b0;
        tick();

        // Straight-line fetch 0, 4, 8.
        fetch_one(64'h0);
        fetch_one(64'h4);
        fetch_one(64'h8);

        // Stall for three cycles during the response at 0xC.
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 64'(inst_valid), 64'd1);
            check("hold_pc", inst_pc, 64'hC);
            check("hold_data", 64'(inst_data), 64'(mk_data(64'hC)));
            check("hold_no_req", 64'(imem.req_valid), 64'd0);
        end
        stall = 1'b0;
        tick();
        check("release_valid", 64'(inst_valid), 64'd0);
        check("release_addr", imem.req_addr, 64'h10);

        // Taken branch while holding: the held instruction is dropped.
        tick();
        stall = 1'b1;
        tick();
        check("hold2_valid", 64'(inst_valid), 64'd1);
        set_branch(64'h40, 64'h8);
        tick();
        clear_branch();
        stall = 1'b0;
        check("hold_drop_valid", 64'(inst_valid), 64'd0);
        check("hold_drop_redirect", 64'(redirect), 64'd1);
        fetch_one(64'h50);

        // Taken while waiting: pending response discarded, fetch at 0x120.
        rsp_delay = 1;
        tick();
        set_branch(64'h100, 64'h10);
        tick();
        clear_branch();
        check("wait_redirect", 64'(redirect), 64'd1);
        check("wait_inst_valid", 64'(inst_valid), 64'd0);
        check("wait_no_req", 64'(imem.req_valid), 64'd0);
        tick();
        check("discard_inst_valid", 64'(inst_valid), 64'd0);
        check("discard_redirect", 64'(redirect), 64'd0);
        rsp_delay = 0;
        fetch_one(64'h120);

        // Response and taken branch in the same cycle.
        tick();
        set_branch(64'h300, 64'h20);
        tick();
        clear_branch();
        check("same_inst_valid", 64'(inst_valid), 64'd0);
        check("same_redirect", 64'(redirect), 64'd1);
        fetch_one(64'h340);

        // Taken while the request is not yet accepted: reissued at target.
        imem.req_ready = 1'b0;
        set_branch(64'h200, 64'h8);
        tick();
        clear_branch();
        check("req_redirect", 64'(redirect), 64'd1);
        imem.req_ready = 1'b1;
        fetch_one(64'h210);

        // Target arithmetic wraps, then PC+4 wraps from the top of memory.
        imem.req_ready = 1'b0;
        set_branch(64'hFFFF_FFFF_FFFF_FFF0, 64'h10);
        tick();
        check("target_wrap", imem.req_addr, 64'h10);
        set_branch(64'hFFFF_FFFF_FFFF_FFF0, 64'h6);
        tick();
        clear_branch();
        imem.req_ready = 1'b1;
        fetch_one(64'hFFFF_FFFF_FFFF_FFFC);
        check("pc_wrap", imem.req_addr, 64'h0);

        // Reset with a fetch outstanding; the late response is ignored.
        rsp_delay = 1;
        tick();
        reset = 1'b1;
        tick();
        check("midrst_req_valid", 64'(imem.req_valid), 64'd0);
        reset = 1'b0;
        tick();
        check("midrst_inst_valid", 64'(inst_valid), 64'd0);
        rsp_delay = 0;
        fetch_one(64'h0);

        // Branch target with bit 1 set.
        imem.req_ready = 1'b0;
        set_branch(64'h0, 64'h1);
        tick();
        clear_branch();
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        check("trap_pulse", 64'(misalign_trap), 64'd1);
        check("trap_no_redirect", 64'(redirect), 64'd0);
        check("trap_no_req", 64'(imem.req_valid), 64'd0);
        imem.req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trap_clear", 64'(misalign_trap), 64'd0);
            check("trap_idle", 64'(imem.req_valid), 64'd0);
        end
`else
        check("misalign_redirect", 64'(redirect), 64'd1);
        imem.req_ready = 1'b1;
        fetch_one(64'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, sets the first fetch address after reset.
REQ-002 Parameter XLEN, default 64, sets the PC and address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  instruction memory accepts the request.
REQ-008 imem_req_addr  output  XLEN  fetch address.
REQ-009 imem_rsp_valid  input  1  fetch data returned.
REQ-010 imem_rsp_data  input  32  fetched instruction.
REQ-011 inst_valid  output  1  instruction presented to decode.
REQ-012 inst_pc  output  XLEN  PC of the presented instruction.
REQ-013 inst_data  output  32  presented instruction.
REQ-014 br_valid  input  1  branch resolved by execute this cycle.
REQ-015 br_branch, br_zero  input  1 each  branch-type flag and ALU zero flag.
REQ-016 br_pc, br_imm  input  XLEN each  PC of the branch and its sign-extended immediate.
REQ-017 redirect  output  1  one-cycle pulse when a taken branch redirects fetch.
REQ-018 misalign_trap  output  1  misaligned target detected (present only with the macro).

Function
REQ-019 The block SHALL have states BOOT, REQ, WAIT and HOLD, with at most one outstanding fetch.
REQ-020 BOOT: PC=RESET_VECTOR, no request; always go to REQ next cycle.
REQ-021 REQ: imem_req_valid=1, addr=PC; on imem_req_ready go to WAIT; valid and addr stay stable until accepted.
REQ-022 WAIT: on imem_rsp_valid with stall=0, present the instruction (inst_valid=1 for exactly one cycle), set PC=PC+4, and go to REQ.
REQ-023 WAIT: on imem_rsp_valid with stall=1, capture data in a holding register and go to HOLD.
REQ-024 HOLD: keep inst_valid=1 with stable inst_pc and inst_data until stall=0, then set PC=PC+4 and go to REQ.
REQ-025 taken = br_valid & br_branch & br_zero; target = br_pc + (br_imm << 1), truncated to XLEN (wraps modulo 2^XLEN).
REQ-026 On taken: redirect=1 for one cycle, PC=target next cycle, and any held or presented instruction is dropped (inst_valid=0 that cycle).
REQ-027 Taken in REQ before acceptance: the request is withdrawn and reissued at target next cycle.
REQ-028 Taken in WAIT: set a discard flag and remain in WAIT; the pending response is consumed without presentation, then go to REQ at target.
REQ-029 A response arriving in the same cycle as taken SHALL be discarded; the redirect wins.
REQ-030 PC+4 SHALL wrap from 2^XLEN-4 to 0 without error.
REQ-031 imem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-032 Reset SHALL force BOOT and set PC=RESET_VECTOR, imem_req_valid=0, inst_valid=0, inst_pc=0, inst_data=0, redirect=0, misalign_trap=0, and discard flag=0.
REQ-033 Reset mid-fetch SHALL abandon the outstanding request; a later response is ignored per REQ-031.

Configuration
REQ-034 Macro PC_SEQ_MISALIGN_TRAP_EN: when defined, a taken target with target[1]=1 asserts misaligned_trap for one cycle, suppresses redirect and the fetch, and holds in BOOT-like idle until reset.
REQ-035 Without the macro, the misaligned_trap port is absent and target[1] is ignored; the fetch proceeds at target.

Structure
REQ-036 A shared package SHALL hold the state enum, the PC increment constant (4), and the branch shift amount (1).
REQ-037 One sub-module, pc_next_calc, SHALL be natural: combinational PC+4 and branch target and taken select.

Verification
REQ-038 Reset, then ready=1 and rsp after 1 cycle -> fetch addresses 0, 4, 8; inst_pc follows the same sequence.
REQ-039 stall=1 for 3 cycles during a response -> inst_valid held 3 cycles with stable data; PC advances only after release.
REQ-040 Taken branch with br_pc=0x100 and br_imm=0x10 while in WAIT -> pending response dropped, redirect pulse, next request addr=0x120.
REQ-041 rsp_valid and taken in the same cycle -> no inst_valid; next request at target.
REQ-042 PC=0xFFFF_FFFF_FFFF_FFFC fetch completes -> next request addr=0.
REQ-043 Macro defined, br_pc=0x0, br_imm=0x1 taken -> misalign_trap=1, no redirect, no further requests.
